// File: rtl/gshare_spec_pred_if.sv
// Fetch/resolve bus of the gshare predictor: prediction request and branch update.
// The master side is the pipeline; the slave side is the predictor.
interface gshare_spec_pred_if #(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned HIST_W = 5
);
  logic [IDX_W-1:0]  w_radr;
  logic              w_rvld;
  logic              w_pred;
  logic [HIST_W-1:0] w_phist;
  logic              w_we;
  logic [IDX_W-1:0]  w_wadr;
  logic [HIST_W-1:0] w_uhist;
  logic              w_tkn;
  logic              w_mispred;
  logic              w_busy;

  modport master (
    output w_radr, w_rvld, w_we, w_wadr, w_uhist, w_tkn, w_mispred,
    input  w_pred, w_phist, w_busy
  );

  modport slave (
    input  w_radr, w_rvld, w_we, w_wadr, w_uhist, w_tkn, w_mispred,
    output w_pred, w_phist, w_busy
  );
endinterface

// File: rtl/gshare_spec_pred.sv
// Gshare direction predictor with a speculative global history, mispredict repair
// and a post-reset sweep that initialises every counter.
module gshare_spec_pred #(
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned HIST_W   = 5,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned INIT_CNT = 1
) (
  input logic                 w_clk,
  input logic                 w_rst_n,
  gshare_spec_pred_if.slave   bus
);

  localparam int unsigned Depth = 1 << IDX_W;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  sweep_q, sweep_d;
  logic              busy_q, busy_d;
  logic [HIST_W-1:0] bhr_q, bhr_d;

  logic [CNT_W-1:0]  mem_q [Depth];

  logic [IDX_W-1:0]  ridx, widx, mem_wadr;
  logic [CNT_W-1:0]  rcnt, wcnt, mem_wdata;
  logic              mem_we;
  logic              pred;

  always_comb begin
    ridx = bus.w_radr ^ IDX_W'(bhr_q);
    rcnt = mem_q[ridx];
    pred = (state_q == StRun) && rcnt[CNT_W-1];
    // Update indexes with the history the branch was predicted under, not the current one.
    widx = bus.w_wadr ^ IDX_W'(bus.w_uhist);
    wcnt = mem_q[widx];
  end

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    busy_d    = busy_q;
    bhr_d     = bhr_q;
    mem_we    = 1'b0;
    mem_wadr  = widx;
    mem_wdata = wcnt;
    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_wadr  = sweep_q;
        mem_wdata = CNT_W'(INIT_CNT);
        sweep_d   = sweep_q + IDX_W'(1);
        if (&sweep_q) begin
          state_d = StRun;
          busy_d  = 1'b0;
        end
      end
      StRun: begin
        if (bus.w_we) begin
          mem_we = 1'b1;
          if (bus.w_tkn && !(&wcnt)) begin
            mem_wdata = wcnt + CNT_W'(1);
          end else if (!bus.w_tkn && (wcnt != '0)) begin
            mem_wdata = wcnt - CNT_W'(1);
          end
        end
        // Repair wins over a same-cycle wrong-path prediction shift.
        if (bus.w_we && bus.w_mispred) begin
          bhr_d = HIST_W'({bus.w_tkn, bus.w_uhist} >> 1);
        end else if (bus.w_rvld) begin
          bhr_d = HIST_W'({pred, bhr_q} >> 1);
        end
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= StInit;
      sweep_q <= '0;
      busy_q  <= 1'b1;
      bhr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      busy_q  <= busy_d;
      bhr_q   <= bhr_d;
    end
  end

  // Table is not reset; the sweep after reset release initialises it.
  always_ff @(posedge w_clk) begin
    if (mem_we) begin
      mem_q[mem_wadr] <= mem_wdata;
    end
  end

  assign bus.w_pred  = pred;
  assign bus.w_phist = bhr_q;
  assign bus.w_busy  = busy_q;

endmodule

// File: tb/tb_gshare_spec_pred.sv
// Directed bench for gshare_spec_pred: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares whenever a probe or a prediction is presented.
module tb_gshare_spec_pred;

  logic w_clk = 1'b0;
  logic w_rst_n;
  logic probe;

  always #5 w_clk = ~w_clk;

  gshare_spec_pred_if #(.IDX_W(5), .HIST_W(5)) bus ();

  gshare_spec_pred #(
    .IDX_W(5), .HIST_W(5), .CNT_W(2), .INIT_CNT(1)
  ) dut (
    .w_clk  (w_clk),
    .w_rst_n(w_rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic       pred;
    logic [4:0] phist;
    logic       busy;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge w_clk) begin
    if (probe || bus.w_rvld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: output presented with no expected entry queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.w_pred !== e.pred || bus.w_phist !== e.phist || bus.w_busy !== e.busy) begin
          errors++;
          $display("FAIL %s: pred/phist/busy got %b/%b/%b want %b/%b/%b", e.name,
                   bus.w_pred, bus.w_phist, bus.w_busy, e.pred, e.phist, e.busy);
        end
      end
    end
  end

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic clr();
    bus.w_radr    = '0;
    bus.w_rvld    = 1'b0;
    bus.w_we      = 1'b0;
    bus.w_wadr    = '0;
    bus.w_uhist   = '0;
    bus.w_tkn     = 1'b0;
    bus.w_mispred = 1'b0;
    probe         = 1'b0;
  endtask

  // Queue an expectation for the current cycle's (already driven) inputs, then advance.
  task automatic chk(input string name, input logic p, input logic [4:0] ph, input logic b);
    exp_t e;
    e.pred  = p;
    e.phist = ph;
    e.busy  = b;
    e.name  = name;
    exp_q.push_back(e);
    probe = 1'b1;
    step();
    clr();
  endtask

  task automatic upd(input logic [4:0] wadr, input logic [4:0] uhist, input logic tkn,
                     input logic mis);
    bus.w_we      = 1'b1;
    bus.w_wadr    = wadr;
    bus.w_uhist   = uhist;
    bus.w_tkn     = tkn;
    bus.w_mispred = mis;
    step();
    clr();
  endtask

  initial begin
    clr();
    w_rst_n = 1'b0;
    step();
    chk("reset", 1'b0, 5'b00000, 1'b1);
    w_rst_n = 1'b1;

    // Sweep: busy for exactly 32 cycles, then every entry predicts not-taken.
    for (int i = 0; i < 32; i++) chk("busy", 1'b0, 5'b00000, 1'b1);
    for (int i = 0; i < 32; i++) begin
      bus.w_radr = 5'(i);
      chk("init_rd", 1'b0, 5'b00000, 1'b0);
    end

    // Train entry 7; same-cycle read sees the old value.
    bus.w_we = 1'b1; bus.w_wadr = 5'd7; bus.w_tkn = 1'b1; bus.w_radr = 5'd7;
    chk("no_bypass", 1'b0, 5'b00000, 1'b0);
    bus.w_we = 1'b1; bus.w_wadr = 5'd7; bus.w_tkn = 1'b1; bus.w_radr = 5'd7;
    chk("train_2", 1'b1, 5'b00000, 1'b0);
    bus.w_radr = 5'd7;
    chk("train_3", 1'b1, 5'b00000, 1'b0);

    // Saturation on entry 4.
    repeat (5) upd(5'd4, 5'd0, 1'b1, 1'b0);
    upd(5'd4, 5'd0, 1'b0, 1'b0);
    bus.w_radr = 5'd4; chk("sat_hi", 1'b1, 5'b00000, 1'b0);
    upd(5'd4, 5'd0, 1'b0, 1'b0);
    bus.w_radr = 5'd4; chk("sat_dn", 1'b0, 5'b00000, 1'b0);
    repeat (3) upd(5'd4, 5'd0, 1'b0, 1'b0);
    bus.w_radr = 5'd4; chk("sat_lo", 1'b0, 5'b00000, 1'b0);
    upd(5'd4, 5'd0, 1'b1, 1'b0);
    bus.w_radr = 5'd4; chk("sat_up1", 1'b0, 5'b00000, 1'b0);
    upd(5'd4, 5'd0, 1'b1, 1'b0);
    bus.w_radr = 5'd4; chk("sat_up2", 1'b1, 5'b00000, 1'b0);

    // Speculative history shifting with predicted directions.
    repeat (2) upd(5'd0, 5'd0, 1'b1, 1'b0);
    bus.w_rvld = 1'b1; bus.w_radr = 5'd0;  chk("spec0", 1'b1, 5'b00000, 1'b0);
    bus.w_rvld = 1'b1; bus.w_radr = 5'd23; chk("spec1", 1'b1, 5'b10000, 1'b0);
    bus.w_rvld = 1'b1; bus.w_radr = 5'd31; chk("spec2", 1'b1, 5'b11000, 1'b0);
    bus.w_rvld = 1'b1; bus.w_radr = 5'd29; chk("spec3", 1'b0, 5'b11100, 1'b0);
    bus.w_radr = 5'd9;                     chk("spec4", 1'b1, 5'b01110, 1'b0);

    // Repair with a same-cycle wrong-path prediction; update hits entry 17^22 = 7.
    bus.w_rvld = 1'b1; bus.w_radr = 5'd9;
    bus.w_we = 1'b1; bus.w_mispred = 1'b1; bus.w_tkn = 1'b0;
    bus.w_uhist = 5'b10110; bus.w_wadr = 5'd17;
    chk("rep_cycle", 1'b1, 5'b01110, 1'b0);
    bus.w_radr = 5'd12; chk("rep_bhr", 1'b1, 5'b01011, 1'b0);
    upd(5'd7, 5'd0, 1'b0, 1'b0);
    bus.w_radr = 5'd12; chk("rep_cnt", 1'b0, 5'b01011, 1'b0);
    bus.w_mispred = 1'b1; bus.w_tkn = 1'b1; bus.w_uhist = 5'b11111; bus.w_radr = 5'd12;
    chk("mis_no_we", 1'b0, 5'b01011, 1'b0);
    bus.w_radr = 5'd12; chk("mis_hold", 1'b0, 5'b01011, 1'b0);

    // Aliasing: repair history to 3, then radr 3 reads entry 0.
    upd(5'd4, 5'b00110, 1'b0, 1'b1);
    bus.w_radr = 5'd3; chk("alias0", 1'b1, 5'b00011, 1'b0);
    bus.w_radr = 5'd0; chk("alias3", 1'b0, 5'b00011, 1'b0);

    // Reset mid-run, then mid-sweep at count 10; the sweep must restart from 0.
    w_rst_n = 1'b0;
    chk("rst_run", 1'b0, 5'b00000, 1'b1);
    w_rst_n = 1'b1;
    repeat (10) step();
    w_rst_n = 1'b0;
    chk("rst_mid", 1'b0, 5'b00000, 1'b1);
    w_rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin
        bus.w_rvld = 1'b1; bus.w_radr = 5'd0;
      end
      if (i == 31) begin
        bus.w_we = 1'b1; bus.w_wadr = 5'd5; bus.w_tkn = 1'b1;
        bus.w_mispred = 1'b1; bus.w_uhist = 5'b00000;
      end
      chk("busy2", 1'b0, 5'b00000, 1'b1);
    end
    bus.w_radr = 5'd0; chk("reinit0", 1'b0, 5'b00000, 1'b0);
    bus.w_radr = 5'd5; chk("init_we", 1'b0, 5'b00000, 1'b0);
    bus.w_radr = 5'd7; chk("reinit7", 1'b0, 5'b00000, 1'b0);

    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never checked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
